// File: rtl/traffic_light_ctrl.sv
// Two-way (NS/EW) intersection sequencer with a pedestrian phase, paced by an
// external down-counter timer: each tmr_done advances the phase, each phase entry pulses tmr_start.
module traffic_light_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned T_GREEN  = 20,
  parameter int unsigned T_YELLOW = 4,
  parameter int unsigned T_ALLRED = 2,
  parameter int unsigned T_WALK   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ew_sense,
  input  logic             ped_req,
  input  logic             tmr_done,
  output logic             tmr_start,
  output logic [WIDTH-1:0] tmr_load,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk,
  output logic             ped_pending
);

  typedef enum logic [2:0] {
    S_INIT, S_AR, S_NS_G, S_NS_Y, S_EW_G, S_EW_Y, S_PED
  } state_t;

  typedef enum logic {DIR_NS, DIR_EW} dir_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [WIDTH-1:0] L_GREEN  = WIDTH'(T_GREEN);
  localparam logic [WIDTH-1:0] L_YELLOW = WIDTH'(T_YELLOW);
  localparam logic [WIDTH-1:0] L_ALLRED = WIDTH'(T_ALLRED);
  localparam logic [WIDTH-1:0] L_WALK   = WIDTH'(T_WALK);

  state_t           state, state_nx;
  dir_t             dir, dir_nx;
  logic             start_nx, done_ok, walk_nx, pend_nx;
  logic [WIDTH-1:0] load_nx;
  logic [2:0]       ns_nx, ew_nx;

  // A done pulse arriving while the timer is being (re)loaded is stale.
  assign done_ok = tmr_done & ~tmr_start;

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    start_nx = 1'b0;
    load_nx  = tmr_load;
    ns_nx    = RED;
    ew_nx    = RED;

    unique case (state)
      S_INIT: begin
        state_nx = S_AR;
        dir_nx   = DIR_NS;
      end
      S_AR:   if (done_ok) state_nx = ped_pending     ? S_PED  :
                                      (dir == DIR_NS) ? S_NS_G : S_EW_G;
      S_PED:  if (done_ok) state_nx = (dir == DIR_NS) ? S_NS_G : S_EW_G;
      S_NS_G: if (done_ok) begin
        if (ew_sense || ped_pending) state_nx = S_NS_Y;
        else                         start_nx = 1'b1;
      end
      S_NS_Y: if (done_ok) begin
        state_nx = S_AR;
        dir_nx   = DIR_EW;
      end
      S_EW_G: if (done_ok) state_nx = S_EW_Y;
      S_EW_Y: if (done_ok) begin
        state_nx = S_AR;
        dir_nx   = DIR_NS;
      end
      default: state_nx = S_INIT;
    endcase

    if (state_nx != state) start_nx = 1'b1;

    if (start_nx) begin
      unique case (state_nx)
        S_NS_G, S_EW_G: load_nx = L_GREEN;
        S_NS_Y, S_EW_Y: load_nx = L_YELLOW;
        S_PED:          load_nx = L_WALK;
        default:        load_nx = L_ALLRED;
      endcase
    end

    unique case (state_nx)
      S_NS_G:  ns_nx = GRN;
      S_NS_Y:  ns_nx = YEL;
      S_EW_G:  ew_nx = GRN;
      S_EW_Y:  ew_nx = YEL;
      default: ;
    endcase

    walk_nx = (state_nx == S_PED);
    // Entering PED serves the request; a press in that same cycle is dropped.
    pend_nx = (ped_pending || (ped_req && state != S_PED)) &&
              !(state_nx == S_PED && state != S_PED);
  end

  // NOTE: state and outputs are registered with non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT;
      dir         <= DIR_NS;
      tmr_start   <= 1'b0;
      tmr_load    <= '0;
      ns_light    <= RED;
      ew_light    <= RED;
      walk        <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_nx;
      dir         <= dir_nx;
      tmr_start   <= start_nx;
      tmr_load    <= load_nx;
      ns_light    <= ns_nx;
      ew_light    <= ew_nx;
      walk        <= walk_nx;
      ped_pending <= pend_nx;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: a behavioural down-counter timer
// answers tmr_start, and each phase entry is checked against hand-computed values.
module tb_traffic_light_ctrl;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ew_sense = 1'b0;
  logic        ped_req = 1'b0;
  logic        tmr_done;
  logic        tmr_start;
  logic [31:0] tmr_load;
  logic [2:0]  ns_light, ew_light;
  logic        walk, ped_pending;

  logic [31:0] cnt;
  logic        model_done;
  logic        spur = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign tmr_done = model_done | spur;

  traffic_light_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .ew_sense    (ew_sense),
    .ped_req     (ped_req),
    .tmr_done    (tmr_done),
    .tmr_start   (tmr_start),
    .tmr_load    (tmr_load),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .walk        (walk),
    .ped_pending (ped_pending)
  );

  // Standard timer: load on tmr_start, count down, one-cycle done at expiry.
  always @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      model_done <= 1'b0;
    end else if (tmr_start) begin
      cnt        <= tmr_load;
      model_done <= 1'b0;
    end else begin
      model_done <= (cnt == 32'd1);
      if (cnt != '0) cnt <= cnt - 32'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Safety invariants every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_ns_onehot", 32'($onehot(ns_light)), 32'd1);
      check("inv_ew_onehot", 32'($onehot(ew_light)), 32'd1);
      check("inv_no_conflict", 32'(ns_light != RED && ew_light != RED), 32'd0);
      check("inv_walk_red", 32'(walk && (ns_light != RED || ew_light != RED)), 32'd0);
    end
  end

  // Wait for the next phase-entry pulse, then check the phase it entered.
  task automatic next_phase(input string tag, input logic [31:0] exp_load,
                            input logic [2:0] exp_ns, input logic [2:0] exp_ew,
                            input logic exp_walk);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tmr_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_start_seen"}, 32'(seen), 32'd1);
    check({tag, "_load"}, tmr_load, exp_load);
    check({tag, "_ns"}, 32'(ns_light), 32'(exp_ns));
    check({tag, "_ew"}, 32'(ew_light), 32'(exp_ew));
    check({tag, "_walk"}, 32'(walk), 32'(exp_walk));
  endtask

  initial begin
    // 1: reset state, then NS_G re-arms while nothing is waiting.
    repeat (3) @(negedge clk);
    check("rst_tmr_start", 32'(tmr_start), 32'd0);
    check("rst_tmr_load", tmr_load, 32'd0);
    check("rst_ns", 32'(ns_light), 32'(RED));
    check("rst_ew", 32'(ew_light), 32'(RED));
    check("rst_walk", 32'(walk), 32'd0);
    check("rst_pend", 32'(ped_pending), 32'd0);
    rst = 1'b0;
    next_phase("t1_ar", 32'd2, RED, RED, 1'b0);
    next_phase("t1_nsg", 32'd20, GRN, RED, 1'b0);
    next_phase("t1_rearm1", 32'd20, GRN, RED, 1'b0);
    next_phase("t1_rearm2", 32'd20, GRN, RED, 1'b0);

    // 2: EW demand runs a full cycle back to NS green.
    ew_sense = 1'b1;
    next_phase("t2_nsy", 32'd4, YEL, RED, 1'b0);
    next_phase("t2_ar1", 32'd2, RED, RED, 1'b0);
    next_phase("t2_ewg", 32'd20, RED, GRN, 1'b0);
    next_phase("t2_ewy", 32'd4, RED, YEL, 1'b0);
    next_phase("t2_ar2", 32'd2, RED, RED, 1'b0);
    next_phase("t2_nsg", 32'd20, GRN, RED, 1'b0);
    ew_sense = 1'b0;

    // 3: pedestrian pulse in NS_G is latched and served after clearance.
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    check("t3_pend_set", 32'(ped_pending), 32'd1);
    next_phase("t3_nsy", 32'd4, YEL, RED, 1'b0);
    next_phase("t3_ar", 32'd2, RED, RED, 1'b0);
    next_phase("t3_ped", 32'd10, RED, RED, 1'b1);
    check("t3_pend_clr", 32'(ped_pending), 32'd0);
    next_phase("t3_ewg", 32'd20, RED, GRN, 1'b0);
    next_phase("t3_ewy", 32'd4, RED, YEL, 1'b0);
    next_phase("t3_ar2", 32'd2, RED, RED, 1'b0);
    next_phase("t3_nsg", 32'd20, GRN, RED, 1'b0);

    // 4: button held across the AR->PED edge and through PED is dropped.
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    next_phase("t4_nsy", 32'd4, YEL, RED, 1'b0);
    next_phase("t4_ar", 32'd2, RED, RED, 1'b0);
    ped_req = 1'b1;
    next_phase("t4_ped", 32'd10, RED, RED, 1'b1);
    check("t4_pend_in_ped", 32'(ped_pending), 32'd0);
    next_phase("t4_ewg", 32'd20, RED, GRN, 1'b0);
    ped_req = 1'b0;
    check("t4_pend_after", 32'(ped_pending), 32'd0);
    next_phase("t4_ewy", 32'd4, RED, YEL, 1'b0);
    next_phase("t4_ar2", 32'd2, RED, RED, 1'b0);
    next_phase("t4_nsg", 32'd20, GRN, RED, 1'b0);

    // 5: done pulse coinciding with tmr_start must not advance NS_G.
    ew_sense = 1'b1;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check("t5_no_start", 32'(tmr_start), 32'd0);
    check("t5_stay_ns", 32'(ns_light), 32'(GRN));
    next_phase("t5_nsy", 32'd4, YEL, RED, 1'b0);
    next_phase("t5_ar", 32'd2, RED, RED, 1'b0);
    next_phase("t5_ewg", 32'd20, RED, GRN, 1'b0);
    ew_sense = 1'b0;

    // 6: reset in EW_Y with a pending request, spurious done during INIT.
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    check("t6_pend_set", 32'(ped_pending), 32'd1);
    next_phase("t6_ewy", 32'd4, RED, YEL, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_ns", 32'(ns_light), 32'(RED));
    check("t6_rst_ew", 32'(ew_light), 32'(RED));
    check("t6_rst_walk", 32'(walk), 32'd0);
    check("t6_rst_pend", 32'(ped_pending), 32'd0);
    check("t6_rst_start", 32'(tmr_start), 32'd0);
    @(negedge clk);
    check("t6_rst_start2", 32'(tmr_start), 32'd0);
    rst = 1'b0;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check("t6_ar_start", 32'(tmr_start), 32'd1);
    check("t6_ar_load", tmr_load, 32'd2);
    check("t6_ar_ns", 32'(ns_light), 32'(RED));
    check("t6_ar_walk", 32'(walk), 32'd0);
    next_phase("t6_nsg", 32'd20, GRN, RED, 1'b0);
    check("t6_pend_lost", 32'(ped_pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
